fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
Read-side unloader for the team's synchronous FIFO. It drives the FIFO read enable, captures the registered read data, and presents the words on a valid/ready stream with frame-end tagging. A 2-entry output buffer with credit-based read issue sustains one word per cycle while absorbing downstream back-pressure. It sits between a FIFO instance and any stream consumer, such as a packetizer or DMA write port.

Parameters:
WIDTH, 32, data word width; must match the FIFO WIDTH.
FRAME_LEN, 16, words per frame; m_last marks word FRAME_LEN-1 of each frame; legal range >= 1.

Ports:
clk  input  1  clock; all logic on posedge.
rst  input  1  reset, synchronous, active-high.
enable  input  1  permits new FIFO reads; when low, already-fetched words still drain.
fifo_empty  input  1  FIFO empty flag.
fifo_data  input  WIDTH  FIFO data_out; valid the cycle after a read is issued.
fifo_rd_en  output  1  FIFO read enable.
m_valid  output  1  stream word valid.
m_ready  input  1  consumer ready.
m_data  output  WIDTH  stream word.
m_last  output  1  last word of the current frame.
busy  output  1  high when state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on posedge clk.
- Reset values:
  - m_valid=0, m_data=0, m_last=0, busy=0.
  - Buffer occupancy=0, in-flight flag=0, frame counter=0, state=IDLE.
  - fifo_rd_en is forced 0 in any cycle where rst=1.
- FIFO timing contract:
  - A read is issued when fifo_rd_en=1 and fifo_empty=0 at posedge N.
  - fifo_data holds that word after edge N.
  - The reader captures it into the buffer at posedge N+1 (in-flight flag set at N, cleared at N+1).
- Read issue (combinational):
  - fifo_rd_en = !rst && enable && !fifo_empty && (occ + inflight - pop) < 2, where pop = m_valid && m_ready.
  - fifo_rd_en is never asserted while fifo_empty=1.
- Latency and throughput:
  - First word: m_valid rises 2 cycles after the first fifo_rd_en.
  - Steady state with m_ready=1 and a non-empty FIFO: 1 word per cycle, no bubbles.
- Buffer:
  - 2-entry in-order queue; the head drives m_data and m_valid.
  - m_data and m_last hold stable while m_valid=1 and m_ready=0.
  - Capture and pop in the same cycle are legal; occ is unchanged.
  - The buffer never overflows; the credit rule guarantees this.
- Frame counter:
  - Width max(1, clog2(FRAME_LEN)).
  - Increments on each pop; wraps to 0 after FRAME_LEN-1.
  - m_last = m_valid && (counter == FRAME_LEN-1).
  - FRAME_LEN=1 makes m_last=1 on every word.
- State machine:
  - IDLE: occ=0, inflight=0, and no read issuing. Go to ACTIVE when fifo_rd_en=1.
  - ACTIVE: enable=1. Go to DRAIN if enable falls while occ+inflight>0. Go to IDLE if occ+inflight=0 and no read is issued.
  - DRAIN: enable=0, no reads. Go to IDLE when occ+inflight reaches 0. Go to ACTIVE if enable returns.
- Boundaries:
  - FIFO goes empty mid-stream: the buffer drains and m_valid drops after the last word; the frame counter keeps its position.
  - Reset mid-operation: the buffered word and any in-flight word are discarded. The FIFO pointer has already advanced, so those words are lost by design. The frame counter returns to 0.
  - enable toggling never drops or duplicates a word.

Optional Feature:
Macro FIFO_STREAM_READER_STATS_EN.
- When defined, two extra outputs exist; both reset to 0 on rst.
  - word_count, 32-bit: increments on every pop, wraps.
  - stall_count, 32-bit: increments each cycle with m_valid=1 and m_ready=0, saturates at all-ones.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset: rst=1 for 2 cycles with fifo_empty=0 and enable=1 -> fifo_rd_en=0, m_valid=0, busy=0 throughout.
2. Streaming: 20 words 0x0..0x13 preloaded, m_ready=1, FRAME_LEN=16 -> words in order at 1 word/cycle starting 2 cycles after the first fifo_rd_en; m_last on 0xF only; word 0x13 is index 3 of frame 2.
3. Back-pressure: m_ready low for 5 cycles mid-stream -> m_data frozen, at most 2 reads issued beyond the last pop, no loss or duplication; stall_count=5 with the macro defined.
4. Underrun: 3 words in FIFO then fifo_empty=1 -> 3 pops, m_valid=0 afterwards, busy returns to 0 within 1 cycle of the last pop.
5. Drain: enable=0 while occ=2 -> fifo_rd_en stays 0, both words delivered, state DRAIN then IDLE.
6. Reset mid-stream: rst pulse with occ=2 -> m_valid=0 next cycle; after reset the next delivered word has frame index 0.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
// Read-side unloader for a synchronous FIFO with registered read data. It
// issues FIFO reads under a two-word credit limit, captures each word one
// cycle after its read, and presents the words on a valid/ready stream with
// a frame-end tag on every FRAME_LEN-th word.
//
// Parameters
//   WIDTH      data word width (must match the FIFO)
//   FRAME_LEN  words per frame, >= 1; m_last marks word FRAME_LEN-1
//
// Ports
//   clk          clock, all logic on posedge
//   rst          synchronous active-high reset
//   enable       permits new FIFO reads; fetched words always drain
//   fifo_empty   FIFO empty flag
//   fifo_data    FIFO read data, valid the cycle after a read
//   fifo_rd_en   FIFO read enable
//   m_valid      stream word valid
//   m_ready      stream consumer ready
//   m_data       stream word
//   m_last       last word of the current frame
//   busy         high whenever the reader is not IDLE
//
// Optional build macro FIFO_STREAM_READER_STATS_EN adds two outputs:
//   word_count   32-bit wrapping count of delivered words
//   stall_count  32-bit saturating count of cycles with m_valid && !m_ready
// -----------------------------------------------------------------------------
module fifo_stream_reader #(
  parameter int WIDTH     = 32,
  parameter int FRAME_LEN = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             busy
`ifdef FIFO_STREAM_READER_STATS_EN
  ,
  output logic [31:0]      word_count,
  output logic [31:0]      stall_count
`endif
);

  localparam int             CW       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0]  LAST_IDX = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       occ_q, occ_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] buf0_q, buf0_d;
  logic [WIDTH-1:0] buf1_q, buf1_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             pop;
  logic [1:0]       occ_after_pop;
  logic [2:0]       level_now;
  logic [2:0]       level_next;

`ifdef FIFO_STREAM_READER_STATS_EN
  logic [31:0]      word_count_q, word_count_d;
  logic [31:0]      stall_count_q, stall_count_d;
`endif

  // Head of the buffer drives the stream directly from registers.
  assign m_valid = (occ_q != 2'd0);
  assign m_data  = buf0_q;
  assign m_last  = m_valid && (cnt_q == LAST_IDX);
  assign busy    = (state_q != IDLE);

  // Datapath next-state: credit check, buffer update, frame counter.
  always_comb begin
    pop           = m_valid && m_ready;
    // Words held or owed after this cycle's pop; a read is allowed only if
    // it cannot push that total above the two buffer entries.
    level_now     = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rd_en    = !rst && enable && !fifo_empty && (level_now < 3'd2);
    inflight_d    = fifo_rd_en;

    occ_after_pop = occ_q - {1'b0, pop};
    occ_d         = occ_after_pop + {1'b0, inflight_q};

    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (pop && (occ_q == 2'd2)) begin
      buf0_d = buf1_q;
    end else begin
      buf0_d = buf0_d;
    end
    // The captured word lands behind whatever survives the pop.
    if (inflight_q) begin
      if (occ_after_pop == 2'd0) begin
        buf0_d = fifo_data;
      end else begin
        buf1_d = fifo_data;
      end
    end else begin
      buf1_d = buf1_d;
    end

    if (pop) begin
      cnt_d = (cnt_q == LAST_IDX) ? {CW{1'b0}} : (cnt_q + {{(CW-1){1'b0}}, 1'b1});
    end else begin
      cnt_d = cnt_q;
    end

    level_next = {1'b0, occ_d} + {2'b00, fifo_rd_en};
  end

  // Control state: tracks whether reads may still be issued or only drained.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fifo_rd_en) begin
          state_d = ACTIVE;
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (!enable) begin
          state_d = (level_next != 3'd0) ? DRAIN : IDLE;
        end else if (level_next == 3'd0) begin
          state_d = IDLE;
        end else begin
          state_d = ACTIVE;
        end
      end
      DRAIN: begin
        if (level_next == 3'd0) begin
          state_d = IDLE;
        end else if (enable) begin
          state_d = ACTIVE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FIFO_STREAM_READER_STATS_EN
  // Delivery and stall statistics.
  always_comb begin
    word_count_d = word_count_q + {31'd0, pop};
    if (m_valid && !m_ready && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_count_q  <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      word_count_q  <= word_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign word_count  = word_count_q;
  assign stall_count = stall_count_q;
`endif

  // State, buffer and counter registers; reset discards buffered words.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      buf0_q     <= {WIDTH{1'b0}};
      buf1_q     <= {WIDTH{1'b0}};
      cnt_q      <= {CW{1'b0}};
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

  localparam int W  = 32;
  localparam int FL = 16;

  logic         clk;
  logic         rst;
  logic         enable;
  logic         fifo_empty;
  logic [W-1:0] fifo_data;
  logic         fifo_rd_en;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         m_last;
  logic         busy;
`ifdef FIFO_STREAM_READER_STATS_EN
  logic [31:0]  word_count;
  logic [31:0]  stall_count;
`endif

  fifo_stream_reader #(.WIDTH(W), .FRAME_LEN(FL)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy)
`ifdef FIFO_STREAM_READER_STATS_EN
    ,
    .word_count (word_count),
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  // FIFO model: registered read data, pointers into a word memory.
  logic [W-1:0] mem [1024];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= mem[rd_ptr % 1024];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Reference model: every word pushed must leave in order exactly once,
  // except words the FIFO already gave up when reset hits.
  logic [W-1:0] exp_q[$];
  int exp_idx = 0;
  int rd_total = 0;
  int pop_total = 0;
  int n_cmp = 0;
  int n_err = 0;

  logic         s_valid, s_last, s_rd, s_busy, s_pop, s_rde;
  logic [W-1:0] s_data;
  logic [W-1:0] pe_data;
  logic         pe_last, pe_none;

  task automatic push_word(input logic [W-1:0] w);
    mem[wr_ptr % 1024] = w;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(w);
  endtask

  task automatic flush_fifo();
    while (wr_ptr != rd_ptr) begin
      wr_ptr = wr_ptr - 1;
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end
  endtask

  // Sample outputs mid-cycle, advance the model, then move to the next negedge.
  task automatic tick();
    #1;
    s_valid = m_valid;
    s_data  = m_data;
    s_last  = m_last;
    s_busy  = busy;
    s_rd    = fifo_rd_en && !fifo_empty;
    s_rde   = fifo_rd_en && fifo_empty;
    s_pop   = m_valid && m_ready && !rst;
    pe_none = 1'b0;
    if (s_pop) begin
      if (exp_q.size() == 0) pe_none = 1'b1;
      else pe_data = exp_q.pop_front();
      pe_last   = (exp_idx == FL - 1);
      exp_idx   = (exp_idx + 1) % FL;
      pop_total = pop_total + 1;
    end
    if (s_rd) rd_total = rd_total + 1;
    if (rst) begin
      for (int k = 0; k < rd_total - pop_total; k++)
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      rd_total = pop_total;
      exp_idx  = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(W'(32'hA0 + i));
    @(posedge clk); @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (s_rd !== 1'b0 || s_valid !== 1'b0 || s_busy !== 1'b0 ||
          s_data !== '0 || s_last !== 1'b0) begin
        n_err++;
        $display("FAIL reset_state: rd=%b valid=%b busy=%b data=%h last=%b, want all 0",
                 s_rd, s_valid, s_busy, s_data, s_last);
      end
    end
    flush_fifo();
    rst = 1'b0; enable = 1'b0;
    tick();
  endtask

  task automatic test_streaming();
    int first_rd = -1, first_pop = -1, last_pop = -1, n_pops = 0, n_last = 0;
    logic [W-1:0] last_word = '0;
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 20; i++) push_word(W'(i));
    for (int t = 0; t < 40; t++) begin
      tick();
      if (s_rd && first_rd < 0) first_rd = t;
      if (s_pop) begin
        if (first_pop < 0) first_pop = t;
        last_pop = t; n_pops++;
        if (s_last) begin n_last++; last_word = s_data; end
        n_cmp++;
        if (pe_none || s_data !== pe_data || s_last !== pe_last) begin
          n_err++;
          $display("FAIL stream_word: got %h last=%b, want %h last=%b", s_data, s_last, pe_data, pe_last);
        end
      end
    end
    n_cmp++;
    if (first_pop - first_rd !== 2) begin
      n_err++; $display("FAIL stream_latency: got %0d cycles, want 2", first_pop - first_rd);
    end
    n_cmp++;
    if (n_pops !== 20 || last_pop - first_pop !== 19) begin
      n_err++; $display("FAIL stream_rate: got %0d words over %0d cycles, want 20 over 19", n_pops, last_pop - first_pop);
    end
    n_cmp++;
    if (n_last !== 1 || last_word !== W'(32'hF)) begin
      n_err++; $display("FAIL stream_last: got %0d tags on %h, want 1 on 0000000f", n_last, last_word);
    end
  endtask

  task automatic test_backpressure();
    int n_pops = 0;
    logic [W-1:0] held;
`ifdef FIFO_STREAM_READER_STATS_EN
    logic [31:0] stall_before;
`endif
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 30; i++) push_word(W'($urandom));
    for (int t = 0; t < 20 && n_pops < 6; t++) begin
      tick();
      if (s_pop) begin
        n_pops++; n_cmp++;
        if (pe_none || s_data !== pe_data || s_last !== pe_last) begin
          n_err++; $display("FAIL bp_word_pre: got %h last=%b, want %h last=%b", s_data, s_last, pe_data, pe_last);
        end
      end
    end
`ifdef FIFO_STREAM_READER_STATS_EN
    stall_before = stall_count;
`endif
    m_ready = 1'b0;
    held = m_data;
    for (int t = 0; t < 5; t++) begin
      tick();
      n_cmp++;
      if (s_valid !== 1'b1 || s_data !== held || rd_total - pop_total > 2) begin
        n_err++;
        $display("FAIL bp_hold: valid=%b data=%h outstanding=%0d, want valid=1 data=%h outstanding<=2",
                 s_valid, s_data, rd_total - pop_total, held);
      end
    end
`ifdef FIFO_STREAM_READER_STATS_EN
    n_cmp++;
    if (stall_count - stall_before !== 32'd5) begin
      n_err++; $display("FAIL bp_stall_count: got %0d, want 5", stall_count - stall_before);
    end
`endif
    m_ready = 1'b1;
    for (int t = 0; t < 60; t++) begin
      tick();
      if (s_pop) begin
        n_cmp++;
        if (pe_none || s_data !== pe_data || s_last !== pe_last) begin
          n_err++; $display("FAIL bp_word_post: got %h last=%b, want %h last=%b", s_data, s_last, pe_data, pe_last);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++; $display("FAIL bp_complete: got %0d words undelivered, want 0", exp_q.size());
    end
  endtask

  task automatic test_underrun();
    int n_pops = 0, done_at = -1;
    logic checked = 1'b0;
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_word(W'($urandom));
    for (int t = 0; t < 12; t++) begin
      tick();
      if (done_at >= 0 && t == done_at + 1) begin
        checked = 1'b1; n_cmp++;
        if (s_valid !== 1'b0 || s_busy !== 1'b0) begin
          n_err++; $display("FAIL underrun_idle: valid=%b busy=%b, want 0 0", s_valid, s_busy);
        end
      end
      if (s_pop) begin
        n_pops++; n_cmp++;
        if (pe_none || s_data !== pe_data || s_last !== pe_last) begin
          n_err++; $display("FAIL underrun_word: got %h last=%b, want %h last=%b", s_data, s_last, pe_data, pe_last);
        end
        if (n_pops == 3) done_at = t;
      end
    end
    n_cmp++;
    if (n_pops !== 3 || checked !== 1'b1) begin
      n_err++; $display("FAIL underrun_count: got %0d pops, want 3", n_pops);
    end
  endtask

  task automatic test_drain();
    int n_pops = 0, done_at = -1;
    enable = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(W'($urandom));
    for (int t = 0; t < 3; t++) tick();
    enable = 1'b0;
    tick();
    m_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick();
      n_cmp++;
      if (s_rd !== 1'b0 || s_busy !== (done_at < 0)) begin
        n_err++; $display("FAIL drain_ctrl: rd=%b busy=%b, want rd=0 busy=%b", s_rd, s_busy, done_at < 0);
      end
      if (s_pop) begin
        n_pops++; n_cmp++;
        if (pe_none || s_data !== pe_data || s_last !== pe_last) begin
          n_err++; $display("FAIL drain_word: got %h last=%b, want %h last=%b", s_data, s_last, pe_data, pe_last);
        end
        if (n_pops == 2) done_at = t;
      end
    end
    n_cmp++;
    if (n_pops !== 2 || exp_q.size() !== 2) begin
      n_err++; $display("FAIL drain_count: got %0d pops %0d left, want 2 and 2", n_pops, exp_q.size());
    end
    flush_fifo();
  endtask

  task automatic test_reset_mid();
    int n_pops = 0, last_at = -1;
    enable = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(W'($urandom));
    for (int t = 0; t < 3; t++) tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if (s_rd !== 1'b0) begin
      n_err++; $display("FAIL rstmid_rd: got %b, want 0", s_rd);
    end
    rst = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 14; i++) push_word(W'($urandom));
    tick();
    n_cmp++;
    if (s_valid !== 1'b0) begin
      n_err++; $display("FAIL rstmid_valid: got %b, want 0", s_valid);
    end
    for (int t = 0; t < 30; t++) begin
      tick();
      if (s_pop) begin
        n_pops++; n_cmp++;
        if (s_last) last_at = n_pops;
        if (pe_none || s_data !== pe_data || s_last !== pe_last) begin
          n_err++; $display("FAIL rstmid_word: got %h last=%b, want %h last=%b", s_data, s_last, pe_data, pe_last);
        end
      end
    end
    n_cmp++;
    if (n_pops !== 16 || last_at !== 16) begin
      n_err++; $display("FAIL rstmid_frame: got %0d pops last at %0d, want 16 and 16", n_pops, last_at);
    end
  endtask

  task automatic test_random();
    logic         p_valid = 1'b0, p_ready = 1'b1;
    logic [W-1:0] p_data = '0;
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 2) == 0 && wr_ptr - rd_ptr < 8) push_word(W'($urandom));
      enable  = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      tick();
      n_cmp++;
      if (s_rde !== 1'b0 || rd_total - pop_total > 2 ||
          (p_valid && !p_ready && (s_valid !== 1'b1 || s_data !== p_data))) begin
        n_err++;
        $display("FAIL rand_ctrl: rd_on_empty=%b outstanding=%0d valid=%b data=%h, want 0 <=2 held %h",
                 s_rde, rd_total - pop_total, s_valid, s_data, p_data);
      end
      if (s_pop) begin
        n_cmp++;
        if (pe_none || s_data !== pe_data || s_last !== pe_last) begin
          n_err++; $display("FAIL rand_word: got %h last=%b, want %h last=%b", s_data, s_last, pe_data, pe_last);
        end
      end
      p_valid = s_valid; p_ready = m_ready; p_data = s_data;
    end
    enable = 1'b1; m_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (s_pop) begin
        n_cmp++;
        if (pe_none || s_data !== pe_data || s_last !== pe_last) begin
          n_err++; $display("FAIL rand_flush_word: got %h last=%b, want %h last=%b", s_data, s_last, pe_data, pe_last);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() !== 0 || s_busy !== 1'b0) begin
      n_err++; $display("FAIL rand_complete: got %0d left busy=%b, want 0 left busy=0", exp_q.size(), s_busy);
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; enable = 1'b0; m_ready = 1'b0; fifo_data = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_underrun();
    test_drain();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
